// File: rtl/mips_encode.sv
// Symbolic request to 32-bit MIPS word encoder.
// Encoded words are queued in a small FIFO with valid/ready on both sides.
module mips_encode #(
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_inst,
    output logic [CW-1:0] enc_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          live;
    logic [31:0]   last_q;
    logic [31:0]   word;
    logic [5:0]    funct;
    logic [5:0]    iop;
    logic          push;
    logic          pop;

    // live keeps in_ready low until the first edge after reset release
    assign in_ready  = live && (occ < FULL);
    assign out_valid = (occ != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_inst  = out_valid ? mem[rd_ptr] : last_q;

    always_comb begin
        funct = 6'h20;
        iop   = 6'h08;
        word  = '0;
        unique case (in_op)
            4'd0:  funct = 6'h20;
            4'd1:  funct = 6'h21;
            4'd2:  funct = 6'h22;
            4'd3:  funct = 6'h23;
            4'd4:  funct = 6'h24;
            4'd5:  funct = 6'h25;
            4'd6:  funct = 6'h26;
            4'd7:  funct = 6'h27;
            4'd8:  iop = 6'h08;
            4'd9:  iop = 6'h09;
            4'd10: iop = 6'h0C;
            4'd11: iop = 6'h0D;
            4'd12: iop = 6'h0E;
            4'd13: iop = 6'h0A;
            default: ;
        endcase
        unique case (1'b1)
            !in_op[3]:
                word = {6'h00, in_rs, in_rt, in_rd, 5'd0, funct};
            in_op == 4'd14:
                word = 32'h0000_000C;
            in_op == 4'd15:
                word = {6'h02, in_target};
            default:
                word = {iop, in_rs, in_rt, in_imm};
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            live      <= 1'b0;
            last_q    <= '0;
            enc_count <= '0;
        end else begin
            live <= 1'b1;
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                last_q    <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + AW'(1);
                enc_count <= enc_count + CW'(1);
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + (AW + 1)'(1);
                2'b01:   occ <= occ - (AW + 1)'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_encode.sv
// Directed and streaming checks for mips_encode.
// A second instance with CW=4 shares all inputs to observe counter wrap.
module tb_mips_encode;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [15:0] enc_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_inst4;
    logic [3:0]  enc_count4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_encode #(.DEPTH(2), .CW(16)) dut (
        .clk(clk), .rst_b(rst_b),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .enc_count(enc_count)
    );

    mips_encode #(.DEPTH(2), .CW(4)) dut4 (
        .clk(clk), .rst_b(rst_b),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_inst(out_inst4), .enc_count(enc_count4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_enc(
        input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tg);
        logic [5:0] f;
        logic [5:0] o;
        f = 6'd32 + {2'b00, op};
        case (op)
            4'd8:  o = 6'd8;
            4'd9:  o = 6'd9;
            4'd10: o = 6'd12;
            4'd11: o = 6'd13;
            4'd12: o = 6'd14;
            default: o = 6'd10;
        endcase
        if (op < 4'd8) return {6'd0, rs, rt, rd, 5'd0, f};
        if (op == 4'd14) return 32'd12;
        if (op == 4'd15) return {6'd2, tg};
        return {o, rs, rt, imm};
    endfunction

    task automatic set_req(input logic [3:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           input logic [15:0] imm, input logic [25:0] tg);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tg;
    endtask

    task automatic enc_chk(input string tag, input logic [3:0] op,
                           input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [15:0] imm,
                           input logic [25:0] tg, input logic [31:0] exp);
        set_req(op, rs, rt, rd, imm, tg);
        in_valid = 1'b1;
        chk({tag, " ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk(tag, out_inst, exp);
        step();
    endtask

    task automatic stream(input int n);
        logic [31:0] exp;
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            set_req(4'($urandom_range(15, 0)), 5'($urandom), 5'($urandom),
                    5'($urandom), 16'($urandom), 26'($urandom));
            exp = ref_enc(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
            chk("stream ready", 32'(in_ready), 32'd1);
            step();
            chk("stream valid", 32'(out_valid), 32'd1);
            chk("stream word", out_inst, exp);
            chk("stream word cw4", out_inst4, exp);
        end
        in_valid = 1'b0;
        step();
        chk("stream drained", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_inst", out_inst, 32'd0);
        chk("rst enc_count", 32'(enc_count), 32'd0);
        chk("rst cw4 ready", 32'(in_ready4), 32'd0);
        #5 rst_b = 1'b1;
        #1 chk("ready before edge", 32'(in_ready), 32'd0);
        step();
        chk("ready after edge", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        enc_chk("add", 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820);
        chk("add count", 32'(enc_count), 32'd1);
        chk("add popped", 32'(out_valid), 32'd0);
        chk("hold last", out_inst, 32'h00221820);

        in_valid = 1'b0;
        set_req(4'd7, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF);
        step();
        chk("idle valid", 32'(out_valid), 32'd0);
        chk("idle count", 32'(enc_count), 32'd1);

        enc_chk("addiu", 4'd9, 5'd0, 5'd8, 5'h1F, 16'h0005, 26'h0,
                32'h24080005);
        enc_chk("ori", 4'd11, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'h0,
                32'h3485FFFF);
        enc_chk("syscall", 4'd14, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF,
                26'h3FFFFFF, 32'h0000000C);
        enc_chk("j", 4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000,
                32'h08100000);
        enc_chk("sub junk", 4'd2, 5'd31, 5'd0, 5'd0, 16'hFFFF,
                26'h3FFFFFF, 32'h03E00022);
        enc_chk("slti", 4'd13, 5'd2, 5'd3, 5'h1F, 16'h8001, 26'h0,
                32'h28438001);
        chk("count 7", 32'(enc_count), 32'd7);

        out_ready = 1'b0;
        set_req(4'd4, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        in_valid = 1'b1;
        step();
        chk("bp A head", out_inst, 32'h00210824);
        chk("bp ready 1", 32'(in_ready), 32'd1);
        set_req(4'd5, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0);
        step();
        set_req(4'd6, 5'd3, 5'd3, 5'd3, 16'h0, 26'h0);
        chk("bp full", 32'(in_ready), 32'd0);
        chk("bp A still", out_inst, 32'h00210824);
        step();
        chk("bp stall ready", 32'(in_ready), 32'd0);
        chk("bp stable", out_inst, 32'h00210824);
        out_ready = 1'b1;
        step();
        chk("bp no push on pop", 32'(in_ready), 32'd1);
        chk("bp B head", out_inst, 32'h00421025);
        chk("bp count 8", 32'(enc_count), 32'd8);
        step();
        in_valid = 1'b0;
        chk("bp C head", out_inst, 32'h00631826);
        chk("bp C valid", 32'(out_valid), 32'd1);
        chk("bp count 9", 32'(enc_count), 32'd9);
        step();
        chk("bp empty", 32'(out_valid), 32'd0);
        chk("bp count 10", 32'(enc_count), 32'd10);

        stream(100);
        chk("stream count", 32'(enc_count), 32'd110);
        chk("stream count cw4", 32'(enc_count4), 32'd14);

        out_ready = 1'b0;
        set_req(4'd1, 5'd9, 5'd9, 5'd9, 16'h0, 26'h0);
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        chk("queued valid", 32'(out_valid), 32'd1);
        #3 rst_b = 1'b0;
        #1;
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst count", 32'(enc_count), 32'd0);
        chk("arst out_inst", out_inst, 32'd0);
        chk("arst ready", 32'(in_ready), 32'd0);
        step();
        #3 rst_b = 1'b1;
        #1 chk("rel ready low", 32'(in_ready), 32'd0);
        step();
        chk("rel ready", 32'(in_ready), 32'd1);
        chk("rel no stale", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step();
        chk("rel still empty", 32'(out_valid), 32'd0);
        chk("rel count", 32'(enc_count), 32'd0);

        stream(17);
        chk("wrap cw16", 32'(enc_count), 32'd17);
        chk("wrap cw4", 32'(enc_count4), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_encode.md
Name: mips_encode

Overview:
Instruction encoder, the inverse of the decode stage. It accepts symbolic instruction requests (operation code plus register, immediate and target fields) over a valid/ready handshake. It assembles legal 32-bit MIPS instruction words and delivers them in order through an output FIFO with its own valid/ready handshake. It feeds instruction memory loaders and self-checking benches that drive the decode path.

Parameters:
DEPTH, 2, output FIFO entries (power of 2, >=2)
CW, 16, width of the delivered-instruction counter

Ports:
clk  in  1  clock, all state updates on the rising edge
rst_b  in  1  reset, asynchronous, active-low
in_valid  in  1  request present
in_ready  out  1  encoder can accept a request this cycle
in_op  in  4  operation select (table below)
in_rs  in  5  source register
in_rt  in  5  target register
in_rd  in  5  destination register
in_imm  in  16  immediate
in_target  in  26  jump target
out_valid  out  1  FIFO head holds an encoded word
out_ready  in  1  consumer takes the head this cycle
out_inst  out  32  encoded instruction at FIFO head
enc_count  out  CW  number of words delivered (popped)

Behaviour:
- Operation table, in_op -> encoding:
  - R-type {op=0, rs, rt, rd, shamt=0, funct}: 0 ADD funct 0x20, 1 ADDU 0x21, 2 SUB 0x22, 3 SUBU 0x23, 4 AND 0x24, 5 OR 0x25, 6 XOR 0x26, 7 NOR 0x27.
  - I-type {op, rs, rt, imm}: 8 ADDI op 0x08, 9 ADDIU 0x09, 10 ANDI 0x0C, 11 ORI 0x0D, 12 XORI 0x0E, 13 SLTI 0x0A.
  - 14 SYSCALL: word 0x0000000C. All register and immediate inputs are ignored.
  - 15 J: {op=0x02, target}.
- Unused fields never leak into the word:
  - I-type ignores in_rd.
  - R-type ignores in_imm and in_target.
  - The shamt field is always 0.
- Accept: a request is accepted when in_valid && in_ready at a rising edge. The encoded word is written to the FIFO tail at that edge.
- Latency: the word appears at out_inst with out_valid=1 in the cycle after acceptance if the FIFO was empty. There is no combinational path from the in_* ports to out_*.
- in_ready = (occupancy < DEPTH), decoded from registered occupancy only. It does not depend on out_ready: when full, a simultaneous pop does not admit a push in the same cycle.
- Pop: at a rising edge with out_valid && out_ready, the head advances and enc_count increments by 1, wrapping modulo 2^CW.
- Simultaneous push and pop when not full and not empty: occupancy is unchanged and order is preserved.
- Push into empty with out_ready=1: no bypass. The word is popped no earlier than the following cycle.
- out_valid = (occupancy != 0). out_inst is stable while out_valid && !out_ready.
- When out_valid=0, out_inst holds the last popped value (0 after reset).
- in_valid=0 has no effect, whatever the other inputs hold.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (rst_b low, at any time, including mid-transfer):
  - occupancy=0, pointers=0, out_valid=0, out_inst=0, enc_count=0, in_ready=0.
  - in_ready goes to 1 on the first clock edge after rst_b deasserts. Contents in flight are discarded.

Test Plan:
- Reset, then ADD rs=1 rt=2 rd=3 with out_ready=1 -> out_valid=1 one cycle after accept, out_inst=0x00221820, enc_count=1 after the pop.
- ADDIU rs=0 rt=8 imm=0x0005, in_rd=0x1F (garbage) -> 0x24080005. ORI rs=4 rt=5 imm=0xFFFF -> 0x3485FFFF.
- SYSCALL with all fields 1s -> 0x0000000C. J target=0x0100000 -> 0x08100000.
- out_ready=0 with DEPTH=2: push 3 requests back-to-back -> in_ready falls after the 2nd accept and the 3rd waits.
  - Raise out_ready -> words emerge in order; the 3rd is accepted only in the cycle after the first pop.
  - out_inst is held stable while stalled.
- Streaming with in_valid and out_ready both always 1 for 100 random ops:
  - Throughput is 1 word/cycle after the 1-cycle fill.
  - Every word matches a reference model.
  - enc_count=100.
- Assert rst_b low asynchronously with 2 entries queued -> out_valid and enc_count drop to 0 immediately.
  - After release, in_ready=1 from the next edge.
  - No stale word is emitted.
- With CW=4, deliver 17 words -> enc_count wraps to 1.
